// File: rtl/count_sequencer_if.sv
// Command and display bundle between the SW/KEY front end and the BCD counter.
// The counter side takes the slave modport.
interface count_sequencer_if;
   logic       start;
   logic       stop;
   logic       clear;
   logic       load;
   logic [7:0] load_val;
   logic       up;
   logic [7:0] target;
   logic [3:0] Q0;
   logic [3:0] Q1;
   logic       tick;
   logic [1:0] state;
   logic       done;

   modport master (output start, stop, clear, load, load_val, up, target,
                   input  Q0, Q1, tick, state, done);
   modport slave  (input  start, stop, clear, load, load_val, up, target,
                   output Q0, Q1, tick, state, done);
endinterface

// File: rtl/count_sequencer.sv
// Two-digit BCD up/down counter advanced by one shared prescaler tick,
// sequenced by a start/stop/clear/load command FSM with terminal-count detect.
module count_sequencer #(
   parameter int DIV = 50_000_000
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   count_sequencer_if.slave bus
);
   localparam int             PW   = $clog2(DIV);
   localparam logic [PW-1:0]  PMAX = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

   state_t        st;
   logic [PW-1:0] presc;
   logic [3:0]    q0, q1;
   logic [3:0]    n0, n1;
   logic          tick;
   logic          load_ok;

   assign tick    = (st == RUN) && (presc == PMAX);
   assign load_ok = (bus.load_val[7:4] <= 4'd9) && (bus.load_val[3:0] <= 4'd9);

   // Next BCD value with wrap-around in both directions.
   always_comb begin
      n0 = q0;
      n1 = q1;
      if (bus.up) begin
         if (q0 == 4'd9) begin
            n0 = 4'd0;
            n1 = (q1 == 4'd9) ? 4'd0 : q1 + 4'd1;
         end else begin
            n0 = q0 + 4'd1;
         end
      end else begin
         if (q0 == 4'd0) begin
            n0 = 4'd9;
            n1 = (q1 == 4'd0) ? 4'd9 : q1 - 4'd1;
         end else begin
            n0 = q0 - 4'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         st    <= IDLE;
         presc <= '0;
         q0    <= 4'd0;
         q1    <= 4'd0;
      end else if (bus.clear) begin
         st    <= IDLE;
         presc <= '0;
         q0    <= 4'd0;
         q1    <= 4'd0;
      end else if (bus.load && st != RUN) begin
         // An out-of-range nibble leaves everything untouched but still swallows lower commands.
         if (load_ok) begin
            q0    <= bus.load_val[3:0];
            q1    <= bus.load_val[7:4];
            st    <= IDLE;
            presc <= '0;
         end
      end else begin
         if (st == RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
               q0 <= n0;
               q1 <= n1;
            end
         end
         case (st)
            RUN: begin
               if (bus.stop)
                  st <= PAUSE;
               else if (tick && {n1, n0} == bus.target) begin
                  st    <= DONE;
                  presc <= '0;
               end
            end
            IDLE, PAUSE, DONE: if (bus.start) st <= RUN;
            default: st <= IDLE;
         endcase
      end
   end

   assign bus.Q0    = q0;
   assign bus.Q1    = q1;
   assign bus.tick  = tick;
   assign bus.state = st;
   assign bus.done  = (st == DONE);
endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench: expected post-tick counts go into a scoreboard queue,
// a negedge monitor pops one entry for every cycle the DUT raises tick.
module tb_count_sequencer;
   logic clk = 1'b0;
   logic reset;
   count_sequencer_if bus ();

   count_sequencer #(.DIV(4)) dut (.CLOCK_50(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct { logic [7:0] q; logic [1:0] st; } exp_t;
   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   logic prev_tick = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic s, input logic sp, input logic c, input logic l, input logic [7:0] lv);
      bus.start = s; bus.stop = sp; bus.clear = c; bus.load = l; bus.load_val = lv;
      step(1);
      bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
   endtask

   task automatic push(input logic [7:0] q, input logic [1:0] st);
      exp_t e;
      e.q = q; e.st = st;
      sb.push_back(e);
   endtask

   // Monitor: the edge closing a tick cycle must produce the next queued value.
   always @(negedge clk) begin
      exp_t e;
      if (prev_tick) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_tick got Q=%0h want no tick at %0t", {bus.Q1, bus.Q0}, $time);
         end else begin
            e = sb.pop_front();
            chk("tick_q", {bus.Q1, bus.Q0}, e.q);
            chk("tick_state", bus.state, e.st);
         end
      end
      prev_tick = bus.tick;
   end

   initial begin
      reset = 1; bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
      bus.load_val = 8'h00; bus.up = 1; bus.target = 8'h50;
      step(2);
      reset = 0;
      chk("rst_q", {bus.Q1, bus.Q0}, 8'h00);
      chk("rst_state", bus.state, 2'b00);
      chk("rst_tick", bus.tick, 1'b0);
      chk("rst_done", bus.done, 1'b0);

      // 1: tick every 4th RUN cycle, counting up
      push(8'h01, 2'b01); push(8'h02, 2'b01); push(8'h03, 2'b01);
      cmd(1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 12; i++) begin
         chk("t1_tick", bus.tick, (i % 4 == 3));
         step(1);
      end
      chk("t1_state", bus.state, 2'b01);

      // 2: 98 -> 99 -> 00 hits target
      cmd(0, 0, 1, 0, 8'h00);
      chk("t2_clear_state", bus.state, 2'b00);
      bus.up = 1; bus.target = 8'h00;
      cmd(0, 0, 0, 1, 8'h98);
      chk("t2_load_q", {bus.Q1, bus.Q0}, 8'h98);
      push(8'h99, 2'b01); push(8'h00, 2'b11);
      cmd(1, 0, 0, 0, 8'h00);
      step(8);
      chk("t2_done", bus.done, 1'b1);
      for (int i = 0; i < 6; i++) begin
         chk("t2_no_tick", bus.tick, 1'b0);
         step(1);
      end
      chk("t2_q_hold", {bus.Q1, bus.Q0}, 8'h00);

      // 3: counting down through 00 -> 99 to target 98, then resume from DONE
      bus.up = 0; bus.target = 8'h98;
      cmd(0, 0, 0, 1, 8'h01);
      chk("t3_load_state", bus.state, 2'b00);
      chk("t3_load_q", {bus.Q1, bus.Q0}, 8'h01);
      push(8'h00, 2'b01); push(8'h99, 2'b01); push(8'h98, 2'b11);
      cmd(1, 0, 0, 0, 8'h00);
      step(12);
      chk("t3_state_done", bus.state, 2'b11);
      push(8'h97, 2'b01);
      cmd(1, 0, 0, 0, 8'h00);
      step(3);
      chk("t3_resume_tick", bus.tick, 1'b1);
      step(1);

      // 4: stop at presc=2 keeps phase; tick right after resume
      step(2);
      cmd(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 10; i++) begin
         chk("t4_pause_tick", bus.tick, 1'b0);
         step(1);
      end
      chk("t4_pause_q", {bus.Q1, bus.Q0}, 8'h97);
      chk("t4_pause_state", bus.state, 2'b10);
      push(8'h96, 2'b01);
      cmd(1, 0, 0, 0, 8'h00);
      chk("t4_resume_tick", bus.tick, 1'b1);
      step(1);

      // 5: invalid load, command priority, load ignored in RUN
      bus.up = 1; bus.target = 8'hAA;
      cmd(0, 0, 1, 0, 8'h00);
      cmd(0, 0, 0, 1, 8'h42);
      chk("t5_load_q", {bus.Q1, bus.Q0}, 8'h42);
      cmd(0, 0, 0, 1, 8'h3A);
      chk("t5_bad_load_q", {bus.Q1, bus.Q0}, 8'h42);
      chk("t5_bad_load_state", bus.state, 2'b00);
      cmd(1, 0, 0, 0, 8'h00);
      chk("t5_run", bus.state, 2'b01);
      cmd(1, 0, 1, 1, 8'h55);
      chk("t5_prio_state", bus.state, 2'b00);
      chk("t5_prio_q", {bus.Q1, bus.Q0}, 8'h00);
      cmd(1, 0, 0, 0, 8'h00);
      cmd(0, 0, 0, 1, 8'h77);
      chk("t5_run_load_q", {bus.Q1, bus.Q0}, 8'h00);
      chk("t5_run_load_state", bus.state, 2'b01);

      // 6: reset coincident with a tick wins; restart from presc=0
      step(2);
      chk("t6_tick", bus.tick, 1'b1);
      push(8'h00, 2'b00);
      reset = 1;
      step(1);
      reset = 0;
      chk("t6_rst_tick", bus.tick, 1'b0);
      chk("t6_rst_state", bus.state, 2'b00);
      chk("t6_rst_q", {bus.Q1, bus.Q0}, 8'h00);
      push(8'h01, 2'b01);
      cmd(1, 0, 0, 0, 8'h00);
      step(3);
      chk("t6_restart_tick", bus.tick, 1'b1);
      step(4);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
